// File: rtl/i2c_reg_arb.sv
// i2c_reg_arb: round-robin arbiter that lets NPORT host bridges share the
// single register-file access port of the I2C controller. Only one access
// is outstanding at a time, and a watchdog turns a stalled register-file
// access into an error response so no host can hang forever.
module i2c_reg_arb #(
  parameter int NPORT = 3,
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int TOW   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NPORT-1:0]    host_req,
  input  logic [NPORT-1:0]    host_wr,
  input  logic [NPORT*AW-1:0] host_addr,
  input  logic [NPORT*DW-1:0] host_wdata,
  output logic [NPORT-1:0]    host_ack,
  output logic [DW-1:0]       host_rdata,
  output logic                host_err,
  output logic                reg_sel,
  output logic                reg_wr,
  output logic [AW-1:0]       reg_addr,
  output logic [DW-1:0]       reg_wdata,
  input  logic                reg_ready,
  input  logic [DW-1:0]       reg_rdata,
  input  logic                reg_err
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  // The watchdog fires on the edge where the counter would reach 2^TOW-1.
  localparam logic [TOW-1:0] T_LAST    = TOW'((1 << TOW) - 2);
  localparam logic [PW-1:0]  LAST_PORT = PW'(NPORT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [TOW-1:0]   tcnt_q, tcnt_d;
  logic [PW:0]      cand;
  logic [PW-1:0]    pick_idx;
  logic             any_req;
  logic             access_tmo;

  logic [NPORT-1:0] ack_d;
  logic [DW-1:0]    rdata_d;
  logic             err_d;
  logic             sel_d;
  logic             wr_d;
  logic [AW-1:0]    addr_d;
  logic [DW-1:0]    wdata_d;

  assign any_req    = |host_req;
  assign access_tmo = (state_q == ACCESS) && !reg_ready && (tcnt_q == T_LAST);

  // Pick the first requesting port at or after ptr, wrapping past the last port.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NPORT)) begin
        cand = cand - (PW+1)'(NPORT);
      end
      if (host_req[cand[PW-1:0]]) begin
        pick_idx = cand[PW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one grant, one access, one response cycle per transaction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (reg_ready || access_tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; reg_ready wins over a simultaneous timeout.
  always_comb begin
    ack_d   = '0;
    rdata_d = host_rdata;
    err_d   = host_err;
    sel_d   = reg_sel;
    wr_d    = reg_wr;
    addr_d  = reg_addr;
    wdata_d = reg_wdata;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick_idx;
          wr_d    = host_wr[pick_idx];
          addr_d  = host_addr[int'(pick_idx)*AW +: AW];
          wdata_d = host_wdata[int'(pick_idx)*DW +: DW];
          sel_d   = 1'b1;
          tcnt_d  = '0;
        end
      end
      ACCESS: begin
        tcnt_d = tcnt_q + 1'b1;
        if (reg_ready) begin
          sel_d          = 1'b0;
          rdata_d        = reg_wr ? '0 : reg_rdata;
          err_d          = reg_err;
          ack_d[grant_q] = 1'b1;
        end else if (access_tmo) begin
          sel_d          = 1'b0;
          rdata_d        = '0;
          err_d          = 1'b1;
          ack_d[grant_q] = 1'b1;
        end
      end
      RESP: begin
        ptr_d = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Register every output and the arbitration bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      tcnt_q     <= '0;
      host_ack   <= '0;
      host_rdata <= '0;
      host_err   <= 1'b0;
      reg_sel    <= 1'b0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tcnt_q     <= tcnt_d;
      host_ack   <= ack_d;
      host_rdata <= rdata_d;
      host_err   <= err_d;
      reg_sel    <= sel_d;
      reg_wr     <= wr_d;
      reg_addr   <= addr_d;
      reg_wdata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_i2c_reg_arb.sv
// tb_i2c_reg_arb: self-checking bench for the register-access arbiter,
// built with three ports and a 4-bit watchdog (15-cycle timeout).
module tb_i2c_reg_arb;

  localparam int NPORT = 3;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int TOW   = 4;
  localparam int TMAX  = (1 << TOW) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NPORT-1:0]    host_req;
  logic [NPORT-1:0]    host_wr;
  logic [NPORT*AW-1:0] host_addr;
  logic [NPORT*DW-1:0] host_wdata;
  logic [NPORT-1:0]    host_ack;
  logic [DW-1:0]       host_rdata;
  logic                host_err;
  logic                reg_sel;
  logic                reg_wr;
  logic [AW-1:0]       reg_addr;
  logic [DW-1:0]       reg_wdata;
  logic                reg_ready;
  logic [DW-1:0]       reg_rdata;
  logic                reg_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int               port;
    logic             wr;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    int               delay;
    logic [DW-1:0]    srdata;
    logic             serr;
    logic [NPORT-1:0] exp_ack;
    logic [DW-1:0]    exp_rdata;
    logic             exp_err;
    int               exp_sel;
  } vec_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  vec_t vecs [7];
  vec_t v_pre;

  txn_t             tq [NPORT][8];
  int               head [NPORT];
  int               cnt [NPORT];
  int               start_at [NPORT];
  int               total, done, model_ptr, cur_port, acc_cnt, delay;
  int               n_acks, last_t;
  bit               in_txn;
  logic [DW-1:0]    exp_rdata;
  logic             exp_err;
  logic [NPORT-1:0] exp_vec;

  always #5 clk = ~clk;

  i2c_reg_arb #(.NPORT(NPORT), .AW(AW), .DW(DW), .TOW(TOW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_req   (host_req),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_err   (host_err),
    .reg_sel    (reg_sel),
    .reg_wr     (reg_wr),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_ready  (reg_ready),
    .reg_rdata  (reg_rdata),
    .reg_err    (reg_err)
  );

  // Compare one value and log any difference.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one host port's request and payload.
  task automatic applyStimulus(input int port, input logic req, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    host_req[port]              = req;
    host_wr[port]               = wr;
    host_addr[port*AW +: AW]    = addr;
    host_wdata[port*DW +: DW]   = wdata;
  endtask

  // One single-port transaction with a register file that answers after
  // 'delay' extra ACCESS cycles (delay >= 15 never answers).
  task automatic runVector(input vec_t v, input string tag);
    int               sel_cnt = 0;
    int               samples = 0;
    bit               seen    = 0;
    logic [NPORT-1:0] ack_v   = '0;
    logic [DW-1:0]    rd_v    = '0;
    logic             err_v   = 1'b0;
    @(negedge clk);
    applyStimulus(v.port, 1'b1, v.wr, v.addr, v.wdata);
    reg_ready = 1'b0;
    reg_rdata = v.srdata;
    reg_err   = v.serr;
    while (!seen && samples < 60) begin
      @(negedge clk);
      samples++;
      if (host_ack != '0) begin
        seen  = 1;
        ack_v = host_ack;
        rd_v  = host_rdata;
        err_v = host_err;
        host_req[v.port] = 1'b0;
        reg_ready = 1'b0;
      end else if (reg_sel) begin
        sel_cnt++;
        if (sel_cnt == 1) begin
          checkOutput({tag, "_reg_addr"},  reg_addr,  v.addr);
          checkOutput({tag, "_reg_wr"},    reg_wr,    v.wr);
          checkOutput({tag, "_reg_wdata"}, reg_wdata, v.wdata);
        end
        reg_ready = (sel_cnt >= v.delay + 1);
      end
    end
    checkOutput({tag, "_ack_seen"},    seen,    1);
    checkOutput({tag, "_ack"},         ack_v,   v.exp_ack);
    checkOutput({tag, "_rdata"},       rd_v,    v.exp_rdata);
    checkOutput({tag, "_err"},         err_v,   v.exp_err);
    checkOutput({tag, "_sel_cycles"},  sel_cnt, v.exp_sel);
    checkOutput({tag, "_ack_latency"}, samples, v.exp_sel + 1);
    @(negedge clk);
    checkOutput({tag, "_ack_pulse"},   host_ack, 0);
    checkOutput({tag, "_sel_after"},   reg_sel,  0);
  endtask

  // Hard stop in case the DUT wedges the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    vecs[0] = '{0, 1'b0, 8'h04, 32'h0000_0000, 1,  32'h0000_00A5, 1'b0, 3'b001, 32'h0000_00A5, 1'b0, 2};
    vecs[1] = '{1, 1'b1, 8'h20, 32'hDEAD_BEEF, 0,  32'h1234_5678, 1'b1, 3'b010, 32'h0000_0000, 1'b1, 1};
    vecs[2] = '{2, 1'b0, 8'h30, 32'h0102_0304, 2,  32'hCAFE_F00D, 1'b0, 3'b100, 32'hCAFE_F00D, 1'b0, 3};
    vecs[3] = '{0, 1'b0, 8'hFF, 32'h0000_0001, 14, 32'h1111_2222, 1'b0, 3'b001, 32'h1111_2222, 1'b0, 15};
    vecs[4] = '{1, 1'b0, 8'h01, 32'h0000_0002, 15, 32'h3333_4444, 1'b0, 3'b010, 32'h0000_0000, 1'b1, 15};
    vecs[5] = '{2, 1'b1, 8'h7C, 32'h8765_4321, 3,  32'h5555_6666, 1'b0, 3'b100, 32'h0000_0000, 1'b0, 4};
    vecs[6] = '{0, 1'b0, 8'h08, 32'h0000_0003, 0,  32'h0BAD_F00D, 1'b1, 3'b001, 32'h0BAD_F00D, 1'b1, 1};
    v_pre   = '{1, 1'b0, 8'h44, 32'h0000_0000, 0,  32'h4444_4444, 1'b0, 3'b010, 32'h4444_4444, 1'b0, 1};

    rst_n      = 1'b0;
    host_req   = '0;
    host_wr    = '0;
    host_addr  = '0;
    host_wdata = '0;
    reg_ready  = 1'b0;
    reg_rdata  = '0;
    reg_err    = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_host_ack",   host_ack,   0);
    checkOutput("rst_host_rdata", host_rdata, 0);
    checkOutput("rst_host_err",   host_err,   0);
    checkOutput("rst_reg_sel",    reg_sel,    0);
    checkOutput("rst_reg_wr",     reg_wr,     0);
    checkOutput("rst_reg_addr",   reg_addr,   0);
    checkOutput("rst_reg_wdata",  reg_wdata,  0);
    rst_n = 1'b1;

    // All ports request writes continuously with reg_ready tied high.
    for (int i = 0; i < NPORT; i++) begin
      applyStimulus(i, 1'b1, 1'b1, AW'(32'h10 + i), 32'hA000_0000 + i);
    end
    reg_ready = 1'b1;
    n_acks = 0;
    last_t = 0;
    for (int cyc = 0; cyc < 40 && n_acks < 4; cyc++) begin
      @(negedge clk);
      if (reg_sel) begin
        checkOutput("rr_reg_addr",  reg_addr,  32'h10 + (n_acks % NPORT));
        checkOutput("rr_reg_wdata", reg_wdata, 32'hA000_0000 + (n_acks % NPORT));
      end
      if (host_ack != '0) begin
        exp_vec = '0;
        exp_vec[n_acks % NPORT] = 1'b1;
        checkOutput("rr_grant_order", host_ack, exp_vec);
        checkOutput("rr_err",         host_err, 0);
        if (n_acks > 0) checkOutput("rr_spacing", cyc - last_t, 3);
        last_t = cyc;
        n_acks++;
      end
    end
    checkOutput("rr_ack_count", n_acks, 4);
    host_req  = '0;
    reg_ready = 1'b0;

    // Ready while idle must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reg_ready = 1'b1;
      reg_rdata = 32'hFFFF_0000 + i;
      checkOutput("idle_no_ack", host_ack, 0);
      checkOutput("idle_no_sel", reg_sel,  0);
    end
    reg_ready = 1'b0;

    foreach (vecs[i]) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Move ptr to 2, start a port-0 access, then reset in the middle of it.
    runVector(v_pre, "pre_rst");
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 8'h55, 32'h5555_5555);
    reg_ready = 1'b0;
    for (int i = 0; i < 10 && !reg_sel; i++) @(negedge clk);
    checkOutput("rst_mid_sel_before", reg_sel, 1);
    #2;
    rst_n    = 1'b0;
    host_req = '0;
    #1;
    checkOutput("rst_mid_sel",   reg_sel,   0);
    checkOutput("rst_mid_ack",   host_ack,  0);
    checkOutput("rst_mid_addr",  reg_addr,  0);
    checkOutput("rst_mid_wdata", reg_wdata, 0);
    @(negedge clk);
    checkOutput("rst_mid_ack_held", host_ack, 0);
    rst_n = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 8'h61, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 8'h62, 32'h0);
    reg_ready = 1'b1;
    reg_rdata = 32'h0000_7777;
    reg_err   = 1'b0;
    n_acks = 0;
    for (int cyc = 0; cyc < 20 && n_acks < 2; cyc++) begin
      @(negedge clk);
      if (host_ack != '0) begin
        exp_vec = '0;
        exp_vec[n_acks + 1] = 1'b1;
        checkOutput("rst_after_grant", host_ack, exp_vec);
        host_req[n_acks + 1] = 1'b0;
        n_acks++;
      end
    end
    checkOutput("rst_after_ack_count", n_acks, 2);
    reg_ready = 1'b0;
    @(negedge clk);

    // Random multi-port traffic against a transaction-level model.
    total = 0;
    for (int p = 0; p < NPORT; p++) begin
      cnt[p]      = $urandom_range(3, 8);
      head[p]     = 0;
      start_at[p] = $urandom_range(0, 4);
      for (int j = 0; j < cnt[p]; j++) begin
        tq[p][j].wr    = 1'($urandom_range(0, 1));
        tq[p][j].addr  = AW'($urandom());
        tq[p][j].wdata = $urandom();
      end
      total += cnt[p];
    end
    model_ptr = 0;
    done      = 0;
    in_txn    = 0;
    cur_port  = 0;
    acc_cnt   = 0;
    delay     = 0;
    exp_rdata = '0;
    exp_err   = 1'b0;
    for (int cyc = 0; cyc < 3000 && done < total; cyc++) begin
      @(negedge clk);
      if (host_ack != '0) begin
        checkOutput("rnd_ack_in_txn", in_txn, 1);
        exp_vec = '0;
        exp_vec[cur_port] = 1'b1;
        checkOutput("rnd_ack",   host_ack,   exp_vec);
        checkOutput("rnd_rdata", host_rdata, exp_rdata);
        checkOutput("rnd_err",   host_err,   exp_err);
        model_ptr          = (cur_port + 1) % NPORT;
        host_req[cur_port] = 1'b0;
        head[cur_port]++;
        start_at[cur_port] = cyc + $urandom_range(0, 3);
        in_txn = 0;
        done++;
      end
      if (reg_sel) begin
        if (!in_txn) begin
          in_txn   = 1;
          cur_port = -1;
          for (int k = 0; k < NPORT; k++) begin
            if (cur_port < 0 && host_req[(model_ptr + k) % NPORT]) cur_port = (model_ptr + k) % NPORT;
          end
          checkOutput("rnd_grant_has_req", cur_port >= 0, 1);
          if (cur_port < 0) cur_port = 0;
          if (head[cur_port] >= cnt[cur_port]) head[cur_port] = cnt[cur_port] - 1;
          checkOutput("rnd_reg_wr",    reg_wr,    tq[cur_port][head[cur_port]].wr);
          checkOutput("rnd_reg_addr",  reg_addr,  tq[cur_port][head[cur_port]].addr);
          checkOutput("rnd_reg_wdata", reg_wdata, tq[cur_port][head[cur_port]].wdata);
          acc_cnt   = 0;
          delay     = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
          exp_rdata = '0;
          exp_err   = 1'b1;
        end
        acc_cnt++;
        reg_rdata = $urandom();
        reg_err   = 1'($urandom_range(0, 1));
        reg_ready = (acc_cnt >= delay + 1) && (acc_cnt <= TMAX);
        if (reg_ready) begin
          exp_rdata = tq[cur_port][head[cur_port]].wr ? '0 : reg_rdata;
          exp_err   = reg_err;
        end
      end else begin
        reg_ready = 1'($urandom_range(0, 1));
        reg_rdata = $urandom();
        reg_err   = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < NPORT; p++) begin
        if (!host_req[p] && head[p] < cnt[p] && cyc >= start_at[p]) begin
          applyStimulus(p, 1'b1, tq[p][head[p]].wr, tq[p][head[p]].addr, tq[p][head[p]].wdata);
        end
      end
    end
    checkOutput("rnd_all_done", done, total);
    host_req  = '0;
    reg_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
